// File: rtl/serial_in.sv
// rtl/serial_in.sv - 8N1 UART receiver with a small receive FIFO and sticky error flags
// Line is double-synchronized; bits are sampled mid-bit by counting clk cycles from the start edge.
module serial_in #(
  parameter int clks_per_bit = 434,
  parameter int fifo_depth   = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          uart_rx,
  input  logic                          pop,
  input  logic                          clr_err,
  output logic [7:0]                    data,
  output logic                          valid,
  output logic [$clog2(fifo_depth):0]   count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int CW   = $clog2(clks_per_bit);
  localparam int PW   = $clog2(fifo_depth);
  localparam int CNTW = PW + 1;
  localparam logic [CW-1:0]   HALF_LAST = CW'((clks_per_bit >> 1) - 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(clks_per_bit - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(fifo_depth);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shreg, shreg_n;
  logic            rx_m, rx_s;
  logic            push, frame_set;

  logic [7:0]      mem [fifo_depth];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic            full, pop_eff, wr_en;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_n     = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n            = '0;
          shreg_n[bit_idx] = rx_s;
          bit_n            = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            frame_set = 1'b1;
            state_n   = BREAK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      // Wait for the line to return high so a held-low line is not taken as a new start bit.
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign full    = (count == FULL_CNT);
  assign pop_eff = pop & valid;
  // A full FIFO still accepts the byte when the head is popped on the same edge.
  assign wr_en   = push & (~full | pop_eff);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
      if (push && full && !pop_eff) overrun <= 1'b1;
      else if (clr_err)             overrun <= 1'b0;
    end
  end

  assign valid = (count != '0);
  assign data  = valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_serial_in.sv
// tb/tb_serial_in.sv - directed and random frames checked against a byte-queue reference model
module tb_serial_in;

  logic       clk = 1'b0;
  logic       nrst, uart_rx, pop, clr_err;
  logic [7:0] data;
  logic       valid, frame_err, overrun;
  logic [2:0] count;

  serial_in #(.clks_per_bit(8), .fifo_depth(4)) dut (
    .clk(clk), .nrst(nrst), .uart_rx(uart_rx), .pop(pop), .clr_err(clr_err),
    .data(data), .valid(valid), .count(count), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] q[$];
  logic       fe_m = 1'b0;
  logic       ov_m = 1'b0;
  logic [7:0] tmp;
  int         vc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_data"},  {24'd0, data}, {24'd0, (q.size() != 0) ? q[0] : 8'h00});
    chk({tag, "_valid"}, {31'd0, valid}, {31'd0, q.size() != 0});
    chk({tag, "_count"}, {29'd0, count}, q.size());
    chk({tag, "_ferr"},  {31'd0, frame_err}, {31'd0, fe_m});
    chk({tag, "_ovr"},   {31'd0, overrun}, {31'd0, ov_m});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one 10-bit frame; pop_at >= 0 raises pop for one cycle at that bit-time offset.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at, output int vcyc);
    logic [9:0] fr;
    fr   = {stop, b, 1'b0};
    vcyc = -1;
    for (int c = 0; c < 80; c++) begin
      uart_rx = fr[c/8];
      pop     = (c == pop_at);
      @(negedge clk);
      if (vcyc < 0 && valid) vcyc = c + 1;
    end
    pop = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop, input logic popped);
    logic [7:0] t;
    if (popped && q.size() != 0) t = q.pop_front();
    if (!stop)             fe_m = 1'b1;
    else if (q.size() < 4) q.push_back(b);
    else                   ov_m = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input logic stop, input int pop_at);
    int v;
    send_frame(b, stop, pop_at, v);
    model_frame(b, stop, pop_at >= 0);
    if (!stop) begin
      uart_rx = 1'b1;
      idle(4);
    end
  endtask

  task automatic do_pop();
    logic [7:0] t;
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
    if (q.size() != 0) t = q.pop_front();
  endtask

  task automatic do_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    fe_m = 1'b0;
    ov_m = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (q.size() != 0) begin
      check_model(tag);
      do_pop();
    end
    check_model({tag, "_empty"});
  endtask

  initial begin
    nrst = 1'b0; uart_rx = 1'b1; pop = 1'b0; clr_err = 1'b0;
    idle(3);
    check_model("reset");
    nrst = 1'b1;
    idle(4);

    send_frame(8'hA5, 1'b1, -1, vc);
    model_frame(8'hA5, 1'b1, 1'b0);
    chk("latency", {31'd0, (vc >= 76 && vc <= 80)}, 32'd1);
    check_model("single");
    do_pop();
    check_model("single_pop");

    uart_rx = 1'b0;
    idle(2);
    uart_rx = 1'b1;
    idle(12);
    check_model("glitch");

    send_frame(8'h3C, 1'b0, -1, vc);
    model_frame(8'h3C, 1'b0, 1'b0);
    idle(40);
    check_model("frame_err");
    uart_rx = 1'b1;
    idle(4);
    frame(8'h55, 1'b1, -1);
    check_model("after_break");
    do_clr();
    check_model("clr_err");
    do_pop();

    for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1, -1);
    check_model("overrun");
    drain("ovr_drain");
    do_clr();
    check_model("ovr_clr");

    for (int i = 1; i <= 4; i++) frame(8'(i), 1'b1, -1);
    frame(8'hEE, 1'b1, 78);
    check_model("full_pop");
    drain("fp_drain");

    for (int c = 0; c < 35; c++) begin
      uart_rx = (c < 8) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    nrst = 1'b0;
    uart_rx = 1'b1;
    idle(2);
    q.delete();
    fe_m = 1'b0;
    ov_m = 1'b0;
    check_model("rst_mid");
    nrst = 1'b1;
    idle(4);
    check_model("rst_rel");
    frame(8'h81, 1'b1, -1);
    check_model("after_rst");
    do_pop();

    for (int i = 0; i < 10; i++) begin
      frame(8'($urandom), 1'b1, -1);
      check_model("wrap");
      chk("wrap_cnt_le1", {31'd0, count <= 3'd1}, 32'd1);
      do_pop();
    end

    for (int i = 0; i < 24; i++) begin
      tmp = 8'($urandom);
      frame(tmp, ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0) ? 78 : -1);
      check_model("rand");
      if ($urandom_range(0, 1) == 1) do_pop();
      if ($urandom_range(0, 5) == 0) do_clr();
      check_model("rand_post");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
